// File: rtl/mem_resp_if.sv
// ----------------------------------------------------------------------------
// mem_resp_if
// Bus between a memory stimulus bench (master) and the mem_resp responder
// (slave).
//   master drives : cen (active-low select), rd, wr, add, din
//   slave drives  : dout, dvalid, busy, err_both, err_uninit, err_busy,
//                   wr_cnt, rd_cnt
// ----------------------------------------------------------------------------
interface mem_resp_if #(
   parameter int AW = 12,
   parameter int DW = 8,
   parameter int CW = 16
);
   logic          cen;
   logic          rd;
   logic          wr;
   logic [AW-1:0] add;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   logic          dvalid;
   logic          busy;
   logic          err_both;
   logic          err_uninit;
   logic          err_busy;
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;

   modport master (
      output cen, rd, wr, add, din,
      input  dout, dvalid, busy, err_both, err_uninit, err_busy, wr_cnt, rd_cnt
   );

   modport slave (
      input  cen, rd, wr, add, din,
      output dout, dvalid, busy, err_both, err_uninit, err_busy, wr_cnt, rd_cnt
   );
endinterface

// File: rtl/mem_resp.sv
// ----------------------------------------------------------------------------
// mem_resp
// Single-port byte memory answering the cen/rd/wr/add/din/dout bus. After
// reset it zeroes the array (and its valid bits) with a sweep of 2^AW cycles,
// then serves one read or one write per clock. Protocol violations are
// reported as one-cycle error pulses; accepted reads/writes are counted with
// saturating counters.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous reset, active-low
//   bus  - mem_resp_if.slave: cen/rd/wr/add/din in; dout/dvalid (1-cycle
//          read latency), busy (sweep running), err_both/err_uninit/err_busy
//          pulses, wr_cnt/rd_cnt out
// ----------------------------------------------------------------------------
module mem_resp #(
   parameter int AW = 12,
   parameter int DW = 8,
   parameter int CW = 16
) (
   input  logic       clk,
   input  logic       rst,
   mem_resp_if.slave  bus
);
   localparam int DEPTH = 1 << AW;

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] ptr;

   logic [DW-1:0] mem [DEPTH];
   logic          vld [DEPTH];

   // decoded per-cycle actions
   logic          req_rd;
   logic          req_wr;
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [DW-1:0] mem_wd;
   logic          vld_wd;
   logic          do_rd;
   logic          do_wr;
   logic          e_both;
   logic          e_busy;

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_INIT;
      else      state <= state_nxt;
   end

   // ---------------------------------------------------------------- next state
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  if (ptr == AW'(DEPTH - 1)) state_nxt = S_READY;
         S_READY: state_nxt = S_READY;
         default: state_nxt = S_INIT;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      req_rd   = !bus.cen && bus.rd;
      req_wr   = !bus.cen && bus.wr;
      mem_we   = 1'b0;
      mem_wa   = bus.add;
      mem_wd   = bus.din;
      vld_wd   = 1'b0;
      do_rd    = 1'b0;
      do_wr    = 1'b0;
      e_both   = req_rd && req_wr;
      e_busy   = 1'b0;
      bus.busy = (state == S_INIT);
      case (state)
         S_INIT: begin
            // sweep owns the write port; bus requests are rejected
            mem_we = 1'b1;
            mem_wa = ptr;
            mem_wd = '0;
            vld_wd = 1'b0;
            e_busy = req_rd || req_wr;
         end
         S_READY: begin
            if (req_wr && !req_rd) begin
               mem_we = 1'b1;
               vld_wd = 1'b1;
               do_wr  = 1'b1;
            end else if (req_rd && !req_wr) begin
               do_rd  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- storage
   // NOTE: the arrays have no reset branch; the post-reset sweep clears them,
   // which keeps them mappable onto RAM macros.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem[mem_wa] <= mem_wd;
         vld[mem_wa] <= vld_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) ptr <= '0;
      else if (state == S_INIT) ptr <= ptr + 1'b1;
   end

   // ---------------------------------------------------------------- read path
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.dout       <= '0;
         bus.dvalid     <= 1'b0;
         bus.err_uninit <= 1'b0;
         bus.err_both   <= 1'b0;
         bus.err_busy   <= 1'b0;
      end else begin
         if (do_rd) bus.dout <= mem[bus.add];
         bus.dvalid     <= do_rd;
         bus.err_uninit <= do_rd && !vld[bus.add];
         bus.err_both   <= e_both;
         bus.err_busy   <= e_busy;
      end
   end

   // ---------------------------------------------------------------- counters
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.wr_cnt <= '0;
         bus.rd_cnt <= '0;
      end else begin
         if (do_wr && bus.wr_cnt != '1) bus.wr_cnt <= bus.wr_cnt + 1'b1;
         if (do_rd && bus.rd_cnt != '1) bus.rd_cnt <= bus.rd_cnt + 1'b1;
      end
   end

   // Unknown request lines while selected are a bench bug; RTL treats them as
   // no access, this flags them in simulation.
   a_no_x_req: assert property (@(posedge clk) disable iff (!rst)
                                !bus.cen |-> !$isunknown({bus.rd, bus.wr}));

endmodule

// File: tb/tb_mem_resp.sv
// ----------------------------------------------------------------------------
// tb_mem_resp
// Self-checking bench for mem_resp. Reads push their expected data/uninit
// flag into a scoreboard queue; a monitor pops and compares on every dvalid.
// ----------------------------------------------------------------------------
module tb_mem_resp;
   localparam int AW = 12;
   localparam int DW = 8;
   localparam int CW = 16;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_resp_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

   mem_resp #(.AW(AW), .DW(DW), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [DW-1:0] data;
      logic          uninit;
   } rd_exp_t;

   rd_exp_t       sb[$];
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_vld [DEPTH];
   int            m_wr;
   int            m_rd;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      m_wr = 0;
      m_rd = 0;
   endtask

   // drive one cycle of bus inputs at a negedge, return at the next negedge
   task automatic drive(input bit c, input bit r, input bit w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.cen = c;
      bus.rd  = r;
      bus.wr  = w;
      bus.add = a;
      bus.din = d;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      m_mem[a] = d;
      m_vld[a] = 1'b1;
      m_wr++;
      drive(1'b0, 1'b0, 1'b1, a, d);
   endtask

   task automatic do_rd(input logic [AW-1:0] a);
      rd_exp_t e;
      e.data   = m_vld[a] ? m_mem[a] : '0;
      e.uninit = !m_vld[a];
      sb.push_back(e);
      m_rd++;
      drive(1'b0, 1'b1, 1'b0, a, '0);
   endtask

   // count negedge samples with busy=1, bounded
   task automatic wait_ready(input string tag);
      int cnt = 0;
      while (bus.busy && cnt < 5000) begin
         cnt++;
         idle();
      end
      check(tag, cnt, DEPTH);
   endtask

   // scoreboard monitor
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk);
         if (bus.dvalid) begin
            if (sb.size() == 0) begin
               check("dvalid_unexpected", bus.dvalid, 1'b0);
            end else begin
               e = sb.pop_front();
               check("rd_data", bus.dout, e.data);
               check("rd_uninit", bus.err_uninit, e.uninit);
            end
         end else if (bus.err_uninit) begin
            check("uninit_without_dvalid", bus.err_uninit, 1'b0);
         end
      end
   end

   initial begin
      int cnt;
      bus.cen = 1'b1;
      bus.rd  = 1'b0;
      bus.wr  = 1'b0;
      bus.add = '0;
      bus.din = '0;
      model_reset();

      // ---- reset and init sweep
      repeat (2) @(negedge clk);
      check("rst_dout", bus.dout, 0);
      check("rst_dvalid", bus.dvalid, 0);
      check("rst_busy", bus.busy, 1);
      check("rst_wr_cnt", bus.wr_cnt, 0);
      check("rst_rd_cnt", bus.rd_cnt, 0);
      rst = 1'b1;
      cnt = 0;
      while (bus.busy && cnt < 5000) begin
         cnt++;
         if (cnt == 11) check("err_busy", bus.err_busy, 1);
         if (cnt == 12) check("err_busy_pulse", bus.err_busy, 0);
         if (cnt == 10) drive(1'b0, 1'b0, 1'b1, 12'h005, 8'h09);
         else           idle();
      end
      check("busy_cycles", cnt, DEPTH);
      check("init_wr_cnt", bus.wr_cnt, 0);
      check("init_busy_low", bus.busy, 0);

      // ---- write / read
      do_wr(12'h3AA, 8'hAA);
      do_rd(12'h3AB);
      do_rd(12'h3CD);
      do_wr(12'h3AB, 8'hBB);
      do_rd(12'h3AA);
      idle();
      check("wr_cnt_a", bus.wr_cnt, m_wr);
      check("rd_cnt_a", bus.rd_cnt, m_rd);

      // ---- collision: last read returned 0xAA, dout must hold it
      drive(1'b0, 1'b1, 1'b1, 12'h3AA, 8'h55);
      check("err_both", bus.err_both, 1);
      check("both_dout_hold", bus.dout, 8'hAA);
      check("both_no_dvalid", bus.dvalid, 0);
      idle();
      check("err_both_pulse", bus.err_both, 0);
      check("both_wr_cnt", bus.wr_cnt, m_wr);
      check("both_rd_cnt", bus.rd_cnt, m_rd);
      do_rd(12'h3AA);

      // ---- deselect
      do_wr(12'h3AB, 8'hBB);
      drive(1'b1, 1'b0, 1'b1, 12'h3AB, 8'h11);
      check("desel_wr_cnt", bus.wr_cnt, m_wr);
      check("desel_err", {bus.err_both, bus.err_busy}, 0);
      do_rd(12'h3AB);

      // ---- back-to-back and boundary
      do_wr(12'hFFF, 8'hFF);
      do_rd(12'hFFF);
      do_rd(12'h000);
      do_rd(12'h000);
      do_rd(12'h000);
      idle();
      idle();
      check("wr_cnt_b", bus.wr_cnt, m_wr);
      check("rd_cnt_b", bus.rd_cnt, m_rd);

      // ---- reset during a held read
      do_wr(12'h123, 8'h77);
      do_rd(12'h123);
      rst = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 12'h123, 8'h00);
      rst = 1'b1;
      model_reset();
      check("mid_rst_dvalid", bus.dvalid, 0);
      check("mid_rst_dout", bus.dout, 0);
      check("mid_rst_busy", bus.busy, 1);
      check("mid_rst_wr_cnt", bus.wr_cnt, 0);
      wait_ready("resweep_cycles");
      do_rd(12'h123);
      idle();
      idle();
      check("final_rd_cnt", bus.rd_cnt, m_rd);
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
